inst_loader: RTL and testbench



---
 rtl/beef_pkg.sv | 6 +
 rtl/inst_ram.sv | 17 +
 rtl/inst_loader.sv | 66 ++++++
 tb/tb_inst_loader.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/beef_pkg.sv
// beef_pkg: shared types and constants for the instruction loader and its memory
package beef_pkg;
  localparam int INST_W = 9;
  typedef logic [INST_W-1:0] inst_t;
  typedef enum logic [1:0] {IDLE, LOAD, DONE} load_state_t;
endpackage

// File: rtl/inst_ram.sv
// inst_ram: instruction array with one synchronous write port and a combinational read port
module inst_ram #(
  parameter int AW = 16,
  parameter int DW = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] r_mem [2**AW];
  always_ff @(posedge clk)
    if (we) r_mem[waddr] <= wdata;
  assign rdata = r_mem[raddr];
endmodule

// File: rtl/inst_loader.sv
// inst_loader: streams host words into instruction memory from a base address, then pulses Done
module inst_loader
  import beef_pkg::*;
#(
  parameter int IW = 16,
  parameter int DW = INST_W
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [IW-1:0] BaseAddr,
  input  logic [IW:0]   LoadLen,
  input  logic          InValid,
  input  logic [DW-1:0] InData,
  output logic          InReady,
  output logic          Busy,
  output logic          Done,
  output logic [IW:0]   WrCount,
  input  logic [IW-1:0] InstAddress,
  output logic [DW-1:0] InstOut
);
  load_state_t   r_state, w_next;
  logic [IW-1:0] r_ptr;
  logic [IW:0]   r_rem;
  logic [IW:0]   r_cnt;
  logic          w_xfer;
  logic          w_accept;
  assign w_xfer   = InValid && (r_state == LOAD);
  assign w_accept = Start && (r_state == IDLE);
  always_ff @(posedge Clk)
    if (Reset) r_state <= IDLE;
    else       r_state <= w_next;
  always_comb
    w_next = r_state == IDLE ? (Start ? (LoadLen == '0 ? DONE : LOAD) : IDLE) :
             r_state == LOAD ? ((w_xfer && r_rem == (IW+1)'(1)) ? DONE : LOAD) :
             IDLE;
  always_comb begin
    InReady = r_state == LOAD;
    Busy    = r_state != IDLE;
    Done    = r_state == DONE;
  end
  // the pointer is IW bits wide so it wraps naturally at the top of memory
  always_ff @(posedge Clk)
    if (Reset) begin
      r_ptr <= '0;
      r_rem <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_ptr <= BaseAddr;
      r_rem <= LoadLen;
      r_cnt <= '0;
    end else if (w_xfer) begin
      r_ptr <= r_ptr + 1'b1;
      r_rem <= r_rem - 1'b1;
      r_cnt <= r_cnt + 1'b1;
    end
  assign WrCount = r_cnt;
  inst_ram #(.AW(IW), .DW(DW)) u_ram (
    .clk  (Clk),
    .we   (w_xfer),
    .waddr(r_ptr),
    .wdata(InData),
    .raddr(InstAddress),
    .rdata(InstOut)
  );
endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader: randomized load traffic checked every cycle against a transaction-level model
module tb_inst_loader;
  localparam int IW = 16;
  localparam int DW = 9;
  localparam int DEPTH = 1 << IW;
  logic          Clk = 0;
  logic          Reset = 1;
  logic          Start = 0;
  logic [IW-1:0] BaseAddr = '0;
  logic [IW:0]   LoadLen = '0;
  logic          InValid = 0;
  logic [DW-1:0] InData = '0;
  logic          InReady, Busy, Done;
  logic [IW:0]   WrCount;
  logic [IW-1:0] InstAddress = '0;
  logic [DW-1:0] InstOut;
  int total = 0;
  int bad = 0;
  logic [DW-1:0] mdl [DEPTH];
  bit            known [DEPTH];
  int m_phase = 0;
  int m_ptr = 0;
  int m_rem = 0;
  int m_cnt = 0;
  bit armed = 0;
  int q_words [$];

  inst_loader #(.IW(IW), .DW(DW)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .BaseAddr(BaseAddr), .LoadLen(LoadLen),
    .InValid(InValid), .InData(InData), .InReady(InReady), .Busy(Busy), .Done(Done),
    .WrCount(WrCount), .InstAddress(InstAddress), .InstOut(InstOut)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // phase: 0 idle, 1 loading, 2 done pulse
  always @(posedge Clk) begin
    if (Reset) begin
      armed   <= 1;
      m_phase <= 0;
      m_cnt   <= 0;
    end else if (m_phase == 0) begin
      if (Start) begin
        m_cnt   <= 0;
        m_ptr   <= BaseAddr;
        m_rem   <= LoadLen;
        m_phase <= (LoadLen == 0) ? 2 : 1;
      end
    end else if (m_phase == 1) begin
      if (InValid) begin
        mdl[m_ptr]   <= InData;
        known[m_ptr] <= 1;
        m_ptr        <= (m_ptr + 1) % DEPTH;
        m_cnt        <= m_cnt + 1;
        m_rem        <= m_rem - 1;
        if (m_rem == 1) m_phase <= 2;
      end
    end else m_phase <= 0;
  end

  always @(negedge Clk)
    if (armed) begin
      check("busy", Busy, m_phase != 0);
      check("in_ready", InReady, m_phase == 1);
      check("done", Done, m_phase == 2);
      check("wr_count", WrCount, m_cnt);
      if (known[InstAddress]) check("inst_out", InstOut, mdl[InstAddress]);
    end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic start_load(input int b, input int l);
    Start    = 1;
    BaseAddr = b[IW-1:0];
    LoadLen  = l[IW:0];
    tick();
    Start    = 0;
    BaseAddr = IW'($urandom);
    LoadLen  = (IW+1)'($urandom);
  endtask

  // mode 0: always valid, 1: pattern 1,0,0, 2: random; poke_at injects a stray Start
  task automatic feed(input int n, input int mode, input int poke_at);
    int sent = 0;
    int cyc = 0;
    int lim = n * 4 + 20;
    while (sent < n && cyc < lim) begin
      InValid     = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 3 == 0) : 1'($urandom);
      InData      = sent < q_words.size() ? DW'(q_words[sent]) : DW'($urandom);
      InstAddress = IW'($urandom);
      Start       = cyc == poke_at;
      BaseAddr    = 16'h5555;
      LoadLen     = 7;
      @(posedge Clk);
      if (InValid && InReady) sent++;
      #1;
      cyc++;
    end
    InValid = 0;
    Start   = 0;
    check("feed_budget", sent, n);
  endtask

  task automatic wait_done(input int exp_cnt);
    bit seen = 0;
    for (int i = 0; i < 4 && !seen; i++)
      if (Done) seen = 1;
      else tick();
    check("done_seen", seen, 1);
    check("done_wrcount", WrCount, exp_cnt);
    tick();
  endtask

  task automatic sweep(input int b, input int n);
    for (int i = 0; i < n; i++) begin
      InstAddress = IW'(b + i);
      tick();
    end
  endtask

  task automatic peek(input int a, input int exp);
    InstAddress = IW'(a);
    #1;
    check("peek", InstOut, exp);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) known[i] = 0;
    repeat (3) tick();
    Reset = 0;
    repeat (5) tick();
    check("rst_busy", Busy, 0);
    check("rst_ready", InReady, 0);
    check("rst_done", Done, 0);
    check("rst_count", WrCount, 0);
    // full-memory fill: wraps back so the last word sits just below the base
    start_load(16'h8123, DEPTH);
    feed(DEPTH, 0, -1);
    wait_done(DEPTH);
    Reset = 1;
    tick();
    Reset = 0;
    sweep(16'h8120, 6);
    sweep(16'h000E, 8);
    q_words = '{9'h1A5, 9'h0FF, 9'h000, 9'h1FF};
    start_load(16'h0010, 4);
    feed(4, 0, -1);
    wait_done(4);
    peek(16'h0010, 9'h1A5);
    peek(16'h0011, 9'h0FF);
    peek(16'h0012, 9'h000);
    peek(16'h0013, 9'h1FF);
    sweep(16'h0010, 5);
    q_words = '{9'h0AA, 9'h155, 9'h03C, 9'h1C3};
    start_load(16'h0010, 4);
    feed(4, 1, 2);
    wait_done(4);
    peek(16'h0013, 9'h1C3);
    sweep(16'h000F, 6);
    sweep(16'h5554, 9);
    q_words = '{9'h111, 9'h022, 9'h133};
    start_load(16'hFFFE, 3);
    feed(3, 0, -1);
    wait_done(3);
    peek(16'hFFFE, 9'h111);
    peek(16'hFFFF, 9'h022);
    peek(16'h0000, 9'h133);
    q_words = {};
    start_load(16'h0400, 0);
    check("len0_done", Done, 1);
    check("len0_ready", InReady, 0);
    check("len0_count", WrCount, 0);
    tick();
    check("len0_idle", Busy, 0);
    start_load(16'h0200, 5);
    feed(2, 0, -1);
    Reset = 1;
    tick();
    Reset = 0;
    check("mid_rst_busy", Busy, 0);
    check("mid_rst_done", Done, 0);
    check("mid_rst_count", WrCount, 0);
    sweep(16'h01FF, 7);
    for (int k = 0; k < 8; k++) begin
      int b = $urandom;
      int l = $urandom_range(1, 20);
      start_load(b, l);
      feed(l, 2, $urandom_range(0, 4));
      wait_done(l);
      sweep(b, l + 1);
      repeat ($urandom_range(0, 3)) tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
